sca_block_sched: RTL and testbench

SCA_BLOCK_SCHED -- requirements
Module: sca_block_sched

---
 rtl/sca_block_sched_pkg.sv | 37 +++
 rtl/sca_block_sched_if.sv | 33 +++
 rtl/sca_block_sched_fifo.sv | 52 +++++
 rtl/sca_block_sched.sv | 178 +++++++++++++++++
 tb/tb_sca_block_sched.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sca_block_sched_pkg.sv
// Shared widths, limits and bundle types for the SCA block scheduler.
// Pending slots, readout queue entries and the window helper live here.
package cfeb_sched_pkg;

  localparam int NBLK       = 16;
  localparam int BIDW       = 4;
  localparam int NPEND      = 4;
  localparam int L1DLY_BASE = 20;
  localparam int L1AWIN     = 4;
  localparam int L1AW       = 6;
  localparam int AGEW       = 6;
  localparam int CNTW       = 5;
  localparam int SW         = $clog2(NPEND);
  localparam int QW         = BIDW + L1AW;

  typedef logic [BIDW-1:0] blk_id_t;
  typedef logic [L1AW-1:0] l1a_t;
  typedef logic [AGEW-1:0] age_t;
  typedef logic [SW-1:0]   slot_idx_t;

  typedef struct packed {
    logic    valid;
    blk_id_t id;
    age_t    age;
    logic    expired;
  } slot_t;

  typedef struct packed {
    blk_id_t id;
    l1a_t    l1a;
  } rdq_t;

  function automatic age_t win_start(input logic [1:0] x);
    return AGEW'(L1DLY_BASE) + AGEW'({x, 1'b0});
  endfunction

endpackage

// File: rtl/sca_block_sched_if.sv
// Trigger, readout and status signals of the SCA block scheduler.
// master drives requests, slave is the scheduler side.
interface sca_block_sched_if;
  import cfeb_sched_pkg::*;

  logic            lct;
  logic            gtrg;
  logic [1:0]      xl1dlyset;
  logic            rdreq;
  logic            rddone;
  blk_id_t         wblk;
  logic            wstb;
  logic            rdavail;
  logic            rdbusy;
  blk_id_t         rdblk;
  l1a_t            rdl1a;
  logic            lctdrop;
  logic            l1orphan;
  logic [CNTW-1:0] nfree;

  modport master (
    output lct, gtrg, xl1dlyset, rdreq, rddone,
    input  wblk, wstb, rdavail, rdbusy, rdblk,
    input  rdl1a, lctdrop, l1orphan, nfree
  );

  modport slave (
    input  lct, gtrg, xl1dlyset, rdreq, rddone,
    output wblk, wstb, rdavail, rdbusy, rdblk,
    output rdl1a, lctdrop, l1orphan, nfree
  );

endinterface

// File: rtl/sca_block_sched_fifo.sv
// Depth-16 show-ahead FIFO of block entries with occupancy count.
// INIT_FULL preloads ids 0..15 on reset so it can serve as the free pool.
module blk_fifo
  import cfeb_sched_pkg::*;
#(
  parameter int DW        = 4,
  parameter bit INIT_FULL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DW-1:0]   din,
  input  logic            pop,
  output logic [DW-1:0]   dout,
  output logic [CNTW-1:0] count
);

  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [CNTW-1:0] cnt;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CNTW'(DEPTH)) || do_pop);
  assign dout    = mem[rp];
  assign count   = cnt;

  // storage, pointers and occupancy; reset optionally refills 0..15
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= INIT_FULL ? DW'(i) : '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= INIT_FULL ? CNTW'(DEPTH) : '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + PW'(1);
      end
      if (do_pop)
        rp <= rp + PW'(1);
      cnt <= cnt + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

endmodule

// File: rtl/sca_block_sched.sv
// SCA block scheduler: free pool, pending L1A slots, readout queue.
// Blocks cycle pool -> slot -> queue -> active -> pool, or expire back.
module sca_block_sched
  import cfeb_sched_pkg::*;
(
  input logic               clk,
  input logic               rst,
  sca_block_sched_if.slave  bus
);

  slot_t           slots [NPEND];
  l1a_t            l1a_cnt;
  blk_id_t         wblk_q;
  logic            wstb_q;
  logic            lctdrop_q;
  logic            l1orphan_q;
  logic            rdbusy_q;
  blk_id_t         rdblk_q;
  l1a_t            rdl1a_q;

  age_t            s_start;
  age_t            s_last;
  logic [NPEND-1:0] in_win;
  logic [NPEND-1:0] rel_c;
  logic            m_hit;
  slot_idx_t       m_idx;
  logic            r_hit;
  slot_idx_t       r_idx;
  logic            f_hit;
  slot_idx_t       f_idx;
  logic            m_take;
  logic            ret_take;
  logic            rel_now;
  logic            alloc;
  logic            rdavail;
  logic            rd_take;
  logic            pool_push;
  blk_id_t         pool_din;
  blk_id_t         pool_dout;
  logic [CNTW-1:0] pool_cnt;
  rdq_t            q_din;
  rdq_t            q_dout;
  logic [CNTW-1:0] q_cnt;

  assign s_start = win_start(bus.xl1dlyset);
  assign s_last  = s_start + AGEW'(L1AWIN - 1);

  assign ret_take = rdbusy_q && bus.rddone;
  assign rdavail  = (q_cnt != '0) && !rdbusy_q;
  assign rd_take  = bus.rdreq && rdavail;
  assign alloc    = bus.lct && (pool_cnt != '0) && f_hit;

  // slot selection: oldest in-window match, oldest release, lowest free
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    r_hit = 1'b0;
    r_idx = '0;
    f_hit = 1'b0;
    f_idx = '0;
    in_win = '0;
    rel_c  = '0;
    for (int i = 0; i < NPEND; i++) begin
      in_win[i] = slots[i].valid && !slots[i].expired &&
                  (slots[i].age >= s_start) &&
                  (slots[i].age <= s_last);
      if (in_win[i] &&
          (!m_hit || slots[i].age > slots[m_idx].age)) begin
        m_hit = 1'b1;
        m_idx = SW'(i);
      end
      if (!slots[i].valid && !f_hit) begin
        f_hit = 1'b1;
        f_idx = SW'(i);
      end
    end
    m_take = bus.gtrg && m_hit;
    for (int i = 0; i < NPEND; i++) begin
      rel_c[i] = slots[i].valid &&
                 (slots[i].expired || slots[i].age >= s_last) &&
                 !(m_take && m_idx == SW'(i));
      if (rel_c[i] &&
          (!r_hit || slots[i].age > slots[r_idx].age)) begin
        r_hit = 1'b1;
        r_idx = SW'(i);
      end
    end
    rel_now   = r_hit && !ret_take;
    pool_push = ret_take || r_hit;
    pool_din  = ret_take ? rdblk_q : slots[r_idx].id;
    q_din     = '{id: slots[m_idx].id, l1a: l1a_cnt};
  end

  // pending slots: load on allocation, age, expire, clear on match/release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPEND; i++)
        slots[i] <= '0;
    end else begin
      for (int i = 0; i < NPEND; i++) begin
        if (alloc && f_idx == SW'(i)) begin
          slots[i] <= '{valid: 1'b1, id: pool_dout,
                        age: '0, expired: 1'b0};
        end else if (slots[i].valid) begin
          if ((m_take && m_idx == SW'(i)) ||
              (rel_now && r_idx == SW'(i))) begin
            slots[i] <= '0;
          end else begin
            if (slots[i].age != '1)
              slots[i].age <= slots[i].age + AGEW'(1);
            if (rel_c[i])
              slots[i].expired <= 1'b1;
          end
        end
      end
    end
  end

  // registered strobes, L1A counter and active readout block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wblk_q     <= '0;
      wstb_q     <= 1'b0;
      lctdrop_q  <= 1'b0;
      l1orphan_q <= 1'b0;
      l1a_cnt    <= '0;
      rdbusy_q   <= 1'b0;
      rdblk_q    <= '0;
      rdl1a_q    <= '0;
    end else begin
      wstb_q     <= alloc;
      lctdrop_q  <= bus.lct && !alloc;
      l1orphan_q <= bus.gtrg && !m_hit;
      if (alloc)
        wblk_q <= pool_dout;
      if (bus.gtrg)
        l1a_cnt <= l1a_cnt + L1AW'(1);
      if (rd_take) begin
        rdbusy_q <= 1'b1;
        rdblk_q  <= q_dout.id;
        rdl1a_q  <= q_dout.l1a;
      end else if (ret_take) begin
        rdbusy_q <= 1'b0;
      end
    end
  end

  blk_fifo #(.DW(BIDW), .INIT_FULL(1'b1)) u_pool (
    .clk   (clk),
    .rst   (rst),
    .push  (pool_push),
    .din   (pool_din),
    .pop   (alloc),
    .dout  (pool_dout),
    .count (pool_cnt)
  );

  blk_fifo #(.DW(QW), .INIT_FULL(1'b0)) u_rdq (
    .clk   (clk),
    .rst   (rst),
    .push  (m_take),
    .din   (q_din),
    .pop   (rd_take),
    .dout  (q_dout),
    .count (q_cnt)
  );

  assign bus.wblk     = wblk_q;
  assign bus.wstb     = wstb_q;
  assign bus.lctdrop  = lctdrop_q;
  assign bus.l1orphan = l1orphan_q;
  assign bus.rdbusy   = rdbusy_q;
  assign bus.rdblk    = rdblk_q;
  assign bus.rdl1a    = rdl1a_q;
  assign bus.rdavail  = rdavail;
  assign bus.nfree    = pool_cnt;

endmodule

// File: tb/tb_sca_block_sched.sv
// Directed bench for sca_block_sched with hand-computed expectations.
// Cycle numbers count from the first clock after reset release.
module tb_sca_block_sched;
  import cfeb_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  sca_block_sched_if bus ();

  sca_block_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    bus.lct       = 1'b0;
    bus.gtrg      = 1'b0;
    bus.xl1dlyset = 2'd0;
    bus.rdreq     = 1'b0;
    bus.rddone    = 1'b0;

    // reset values before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_nfree", bus.nfree, 16);
    chk("rst_wstb", bus.wstb, 0);
    chk("rst_rdbusy", bus.rdbusy, 0);
    chk("rst_rdavail", bus.rdavail, 0);
    chk("rst_wblk", bus.wblk, 0);
    chk("rst_lctdrop", bus.lctdrop, 0);
    do_reset();

    // single block matched and read out
    go(10);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    chk("m_wstb", bus.wstb, 1);
    chk("m_wblk", bus.wblk, 0);
    chk("m_nfree", bus.nfree, 15);
    step();
    chk("m_wstb_pulse", bus.wstb, 0);
    go(31);
    bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
    chk("m_rdavail", bus.rdavail, 1);
    chk("m_orphan", bus.l1orphan, 0);
    bus.rdreq = 1'b1; step(); bus.rdreq = 1'b0;
    chk("m_rdbusy", bus.rdbusy, 1);
    chk("m_rdblk", bus.rdblk, 0);
    chk("m_rdl1a", bus.rdl1a, 0);
    chk("m_rdavail_busy", bus.rdavail, 0);
    bus.rddone = 1'b1; step(); bus.rddone = 1'b0;
    chk("m_done_busy", bus.rdbusy, 0);
    chk("m_done_nfree", bus.nfree, 16);

    // early L1A orphans, block expires at age 24
    do_reset();
    go(10);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    go(26);
    bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
    chk("o_orphan", bus.l1orphan, 1);
    chk("o_rdavail", bus.rdavail, 0);
    step();
    chk("o_orphan_pulse", bus.l1orphan, 0);
    go(34);
    chk("o_nfree_age23", bus.nfree, 15);
    go(35);
    chk("o_nfree_age24", bus.nfree, 16);

    // offset window 22..25: below edge orphans, top edge matches
    do_reset();
    bus.xl1dlyset = 2'd1;
    go(10);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    go(32);
    bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
    chk("w_orphan_lo", bus.l1orphan, 1);
    go(36);
    bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
    chk("w_orphan_hi", bus.l1orphan, 0);
    chk("w_rdavail", bus.rdavail, 1);
    bus.rdreq = 1'b1; step(); bus.rdreq = 1'b0;
    chk("w_rdl1a", bus.rdl1a, 1);
    chk("w_rdblk", bus.rdblk, 0);
    go(45);
    chk("w_nfree_held", bus.nfree, 15);
    bus.rddone = 1'b1; step(); bus.rddone = 1'b0;
    chk("w_nfree_ret", bus.nfree, 16);
    bus.xl1dlyset = 2'd0;

    // five back-to-back LCTs fill four slots, fifth dropped
    do_reset();
    go(10);
    bus.lct = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("b_wstb", bus.wstb, 1);
      chk("b_wblk", bus.wblk, 32'(k - 1));
    end
    step();
    bus.lct = 1'b0;
    chk("b_drop", bus.lctdrop, 1);
    chk("b_drop_wstb", bus.wstb, 0);
    chk("b_drop_nfree", bus.nfree, 12);
    chk("b_drop_wblk", bus.wblk, 3);
    step();
    chk("b_drop_pulse", bus.lctdrop, 0);
    go(35);
    chk("b_exp_first", bus.nfree, 13);
    go(38);
    chk("b_exp_all", bus.nfree, 16);

    // readout return and expiry on the same cycle
    do_reset();
    go(10);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    go(15);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    go(31);
    bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
    bus.rdreq = 1'b1; step(); bus.rdreq = 1'b0;
    go(39);
    chk("c_nfree_before", bus.nfree, 14);
    chk("c_busy_before", bus.rdbusy, 1);
    bus.rddone = 1'b1; step(); bus.rddone = 1'b0;
    chk("c_nfree_ret", bus.nfree, 15);
    chk("c_busy_clr", bus.rdbusy, 0);
    step();
    chk("c_nfree_exp", bus.nfree, 16);

    // sixteen matched blocks exhaust the pool
    do_reset();
    for (int i = 0; i < 16; i++) begin
      go(10 + 30 * i);
      bus.lct = 1'b1; step(); bus.lct = 1'b0;
      chk("f_wblk", bus.wblk, 32'(i));
      go(31 + 30 * i);
      bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
      chk("f_orphan", bus.l1orphan, 0);
    end
    go(490);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    chk("f_drop", bus.lctdrop, 1);
    chk("f_nfree", bus.nfree, 0);
    chk("f_rdavail", bus.rdavail, 1);
    bus.rdreq = 1'b1; step(); bus.rdreq = 1'b0;
    chk("f_rdblk", bus.rdblk, 0);
    chk("f_rdl1a", bus.rdl1a, 0);

    // reset mid-operation with an active readout and three slots
    do_reset();
    go(10);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    go(31);
    bus.gtrg = 1'b1; step(); bus.gtrg = 1'b0;
    bus.rdreq = 1'b1; step(); bus.rdreq = 1'b0;
    go(34);
    bus.lct = 1'b1;
    step(); step(); step();
    bus.lct = 1'b0;
    go(38);
    chk("r_busy_pre", bus.rdbusy, 1);
    chk("r_nfree_pre", bus.nfree, 12);
    chk("r_wblk_pre", bus.wblk, 3);
    #2 rst = 1'b1;
    #1;
    chk("r_busy", bus.rdbusy, 0);
    chk("r_nfree", bus.nfree, 16);
    chk("r_wblk", bus.wblk, 0);
    chk("r_rdavail", bus.rdavail, 0);
    step();
    rst = 1'b0;
    cyc = 0;
    step();
    chk("r_nfree_post", bus.nfree, 16);
    bus.lct = 1'b1; step(); bus.lct = 1'b0;
    chk("r_wblk_post", bus.wblk, 0);
    chk("r_wstb_post", bus.wstb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
